// File: rtl/cordic_iter_stage.sv
// Iterative CORDIC micro-rotation engine: one shift-add datapath runs i=1..ITER.
// Optional vectoring mode is enabled by defining CORDIC_VECTORING_EN.
module cordic_iter_stage #(
  parameter int WIDTH = 8,
  parameter int OW    = WIDTH + 2,
  parameter int ZW    = 16,
  parameter int ITER  = 7
) (
  input  logic                    C,
  input  logic                    R,
  input  logic                    CE,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [ZW-1:0]    z_in,
`ifdef CORDIC_VECTORING_EN
  input  logic                    mode,
`endif
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OW-1:0]    x_out,
  output logic signed [OW-1:0]    y_out,
  output logic signed [ZW-1:0]    z_out,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int IW   = $clog2(ITER + 1);
  // ROM is tabulated for a 16-bit angle; other ZW values rescale it.
  localparam int SH_L = (ZW >= 16) ? ZW - 16 : 0;
  localparam int SH_R = (ZW < 16) ? 16 - ZW : 0;
  localparam int RND  = (1 << SH_R) >> 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         cnt_q, cnt_d;
  logic signed [OW-1:0]  x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]  z_q, z_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
`ifdef CORDIC_VECTORING_EN
  logic                  vec_q, vec_d;
`endif

  logic signed [OW-1:0]  x_sh, y_sh;
  logic signed [ZW-1:0]  atan_i;
  logic                  d_pos;

  function automatic logic signed [ZW-1:0] atan_rom(input logic [IW-1:0] i);
    int v;
    case (int'(i))
      1:       v = 4836;
      2:       v = 2555;
      3:       v = 1297;
      4:       v = 651;
      5:       v = 326;
      6:       v = 163;
      7:       v = 81;
      8:       v = 41;
      9:       v = 20;
      10:      v = 10;
      11:      v = 5;
      12:      v = 3;
      13:      v = 1;
      14:      v = 1;
      default: v = 0;
    endcase
    return ZW'(((v <<< SH_L) + RND) >>> SH_R);
  endfunction

  always_comb begin
    x_sh   = x_q >>> cnt_q;
    y_sh   = y_q >>> cnt_q;
    atan_i = atan_rom(cnt_q);
`ifdef CORDIC_VECTORING_EN
    // Vectoring steers y toward zero; rotation steers z toward zero.
    d_pos  = vec_q ? y_q[OW-1] : ~z_q[ZW-1];
`else
    d_pos  = ~z_q[ZW-1];
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef CORDIC_VECTORING_EN
    vec_d       = vec_q;
`endif
    if (CE) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_d        = {{(OW-WIDTH){x_in[WIDTH-1]}}, x_in};
            y_d        = {{(OW-WIDTH){y_in[WIDTH-1]}}, y_in};
            z_d        = z_in;
            cnt_d      = IW'(1);
            state_d    = RUN;
            in_ready_d = 1'b0;
`ifdef CORDIC_VECTORING_EN
            vec_d      = mode;
`endif
          end
        end
        RUN: begin
          x_d = d_pos ? x_q - y_sh : x_q + y_sh;
          y_d = d_pos ? y_q + x_sh : y_q - x_sh;
          z_d = d_pos ? z_q - atan_i : z_q + atan_i;
          if (cnt_q == IW'(ITER)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
        DONE: begin
          // Return to IDLE only; the next accept waits one more edge.
          if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef CORDIC_VECTORING_EN
      vec_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef CORDIC_VECTORING_EN
      vec_q       <= vec_d;
`endif
    end
  end

  assign x_out     = x_q;
  assign y_out     = y_q;
  assign z_out     = z_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cordic_iter_stage.sv
// Bench for cordic_iter_stage: vector table plus scoreboard of expected results.
module tb_cordic_iter_stage;
  localparam int WIDTH = 8;
  localparam int OW    = 10;
  localparam int ZW    = 16;
  localparam int ITER  = 7;

  logic C = 1'b0;
  logic R, CE, in_valid, out_ready, in_ready, out_valid;
  logic signed [WIDTH-1:0] x_in, y_in;
  logic signed [ZW-1:0]    z_in;
  logic signed [OW-1:0]    x_out, y_out;
  logic signed [ZW-1:0]    z_out;
  logic                    mode_r;

  cordic_iter_stage #(.WIDTH(WIDTH), .OW(OW), .ZW(ZW), .ITER(ITER)) dut (
    .C(C), .R(R), .CE(CE),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
`ifdef CORDIC_VECTORING_EN
    .mode(mode_r),
`endif
    .in_valid(in_valid), .in_ready(in_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 C = ~C;

  typedef struct { int x; int y; int z; } res_t;
  typedef struct { res_t r; string nm; } exp_t;
  typedef struct { int x; int y; int z; int ex; int ey; int ez; } vec_t;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   atan_t [1:7] = '{4836, 2555, 1297, 651, 326, 163, 81};

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic int wrapn(input int v, input int n);
    return (v <<< (32 - n)) >>> (32 - n);
  endfunction

  function automatic res_t model(input int x0, input int y0, input int z0, input bit m);
    res_t r;
    int x, y, z, xn, yn, d;
    x = x0; y = y0; z = z0;
    for (int i = 1; i <= ITER; i++) begin
      if (m) d = (y < 0) ? 1 : -1;
      else   d = (z >= 0) ? 1 : -1;
      xn = x - d * (y >>> i);
      yn = y + d * (x >>> i);
      z  = wrapn(z - d * atan_t[i], ZW);
      x  = wrapn(xn, OW);
      y  = wrapn(yn, OW);
    end
    r.x = x; r.y = y; r.z = z;
    return r;
  endfunction

  // Scoreboard: compare on the edge where the output handshake will complete.
  always @(negedge C) begin
    if (!R && CE && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_output: got x=%0d with no word expected", x_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.nm, "_x"}, int'(x_out), e.r.x);
        chk({e.nm, "_y"}, int'(y_out), e.r.y);
        chk({e.nm, "_z"}, int'(z_out), e.r.z);
      end
    end
  end

  // Drive one word; returns #1 after the edge on which out_valid rose.
  task automatic send(input int x, input int y, input int z, input bit m,
                      input int ex, input int ey, input int ez,
                      input int gap_at, input bit hold, input string nm,
                      output int lat);
    bit   acc;
    exp_t e;
    acc = 0; lat = 0;
    x_in = WIDTH'(x); y_in = WIDTH'(y); z_in = ZW'(z); mode_r = m;
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge C);
      if (in_ready && CE && !R) begin acc = 1; break; end
    end
    if (!acc) begin
      in_valid = 1'b0;
      chk({nm, "_accept_timeout"}, 0, 1);
      return;
    end
    e.r.x = ex; e.r.y = ey; e.r.z = ez; e.nm = nm;
    exp_q.push_back(e);
    @(posedge C); #1;
    if (hold) begin
      x_in = WIDTH'(x + 37); y_in = WIDTH'(y - 21); z_in = ZW'(z + 1000);
    end else begin
      in_valid = 1'b0;
    end
    acc = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge C); #1;
      lat++;
      if (out_valid) begin acc = 1; break; end
      if (hold && lat == 2) chk({nm, "_in_ready_run"}, int'(in_ready), 0);
      if (gap_at != 0 && lat == gap_at) CE = 1'b0;
      if (gap_at != 0 && lat == gap_at + 3) CE = 1'b1;
    end
    in_valid = 1'b0;
    CE = 1'b1;
    if (!acc) chk({nm, "_out_timeout"}, 0, 1);
    chk({nm, "_latency"}, lat, ITER + ((gap_at != 0) ? 3 : 0));
  endtask

  initial begin
    vec_t tbl[8];
    res_t r;
    int   lat, sx, sy, sz, xs, ys, zs;
    bit   held;

    tbl[0] = '{100, 0, 0, 115, 0, 75};
    begin
      int v[7][3] = '{'{0, 100, 0}, '{-128, -128, 16383}, '{127, 127, -16384},
                      '{-100, 50, 8000}, '{127, -128, 12345}, '{0, 0, 0}, '{-128, 0, -1}};
      for (int i = 0; i < 7; i++) begin
        r = model(v[i][0], v[i][1], v[i][2], 1'b0);
        tbl[i+1] = '{v[i][0], v[i][1], v[i][2], r.x, r.y, r.z};
      end
    end

    R = 1'b1; CE = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode_r = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    repeat (2) @(posedge C);
    #1 R = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_x", int'(x_out), 0);
    chk("rst_y", int'(y_out), 0);
    chk("rst_z", int'(z_out), 0);

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].x, tbl[i].y, tbl[i].z, 1'b0, tbl[i].ex, tbl[i].ey, tbl[i].ez,
           0, 1'b0, $sformatf("vec%0d", i), lat);
      @(posedge C); #1;
    end

    for (int i = 0; i < 4; i++) begin
      sx = $urandom_range(255) - 128;
      sy = $urandom_range(255) - 128;
      sz = $urandom_range(32767) - 16384;
      r = model(sx, sy, sz, 1'b0);
      send(sx, sy, sz, 1'b0, r.x, r.y, r.z, 0, 1'b0, $sformatf("rnd%0d", i), lat);
      @(posedge C); #1;
    end

    // Back-pressure in DONE.
    out_ready = 1'b0;
    send(100, 0, 0, 1'b0, 115, 0, 75, 0, 1'b0, "bp", lat);
    xs = int'(x_out); ys = int'(y_out); zs = int'(z_out);
    held = 1;
    for (int n = 0; n < 5; n++) begin
      @(posedge C); #1;
      if (!out_valid || in_ready || int'(x_out) != xs || int'(y_out) != ys || int'(z_out) != zs)
        held = 0;
    end
    chk("bp_hold", int'(held), 1);
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_in_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    @(posedge C); #1;
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_in_ready", int'(in_ready), 1);

    // in_valid held with different data during RUN.
    r = model(-90, 60, 3000, 1'b0);
    send(-90, 60, 3000, 1'b0, r.x, r.y, r.z, 0, 1'b1, "hold", lat);
    @(posedge C); #1;
    @(posedge C); #1;
    chk("hold_no_second", exp_q.size(), 0);
    chk("hold_idle_valid", int'(out_valid), 0);

    // Reset at RUN i=3.
    x_in = 8'sd100; y_in = 8'sd20; z_in = 16'sd500; in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge C);
      if (in_ready) break;
    end
    @(posedge C); #1 in_valid = 1'b0;
    repeat (2) begin @(posedge C); #1; end
    R = 1'b1;
    @(posedge C); #1 R = 1'b0;
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_x", int'(x_out), 0);
    chk("mid_rst_y", int'(y_out), 0);
    chk("mid_rst_z", int'(z_out), 0);
    send(100, 0, 0, 1'b0, 115, 0, 75, 0, 1'b0, "post_rst", lat);
    @(posedge C); #1;

    // CE low for three edges mid-RUN.
    send(100, 0, 0, 1'b0, 115, 0, 75, 3, 1'b0, "ce_gap", lat);
    @(posedge C); #1;

`ifdef CORDIC_VECTORING_EN
    r = model(64, 64, 0, 1'b1);
    send(64, 64, 0, 1'b1, r.x, r.y, r.z, 0, 1'b0, "vect", lat);
    chk("vect_y_near0", int'(int'(y_out) >= -2 && int'(y_out) <= 2), 1);
    chk("vect_z_near_pi4", int'(int'(z_out) >= 7992 && int'(z_out) <= 8392), 1);
    @(posedge C); #1;
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
